// File: rtl/ws2812_pattern_gen.sv
// Per-pixel colour source for the WS2812 serialiser: palette lookup of a selectable
// pattern, rotated by a phase that advances every PERIOD clocks or on demand.
module ws2812_pattern_gen #(
    parameter  int W_ADDR    = 6,
    parameter  int COLS_LOG2 = 3,
    parameter  int W_DATA    = 24,
    parameter  int N_COLORS  = 8,
    parameter  int PERIOD    = 30000000,
    localparam int W_IDX     = $clog2(N_COLORS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W_ADDR-1:0] addr,
    output logic [W_DATA-1:0] data,
    output logic              done,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic              pause,
    input  logic              step,
    input  logic              pal_we,
    input  logic [W_IDX-1:0]  pal_idx,
    input  logic [W_DATA-1:0] pal_wdata,
    output logic [W_IDX-1:0]  phase
);

    localparam int              W_CNT    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(PERIOD - 1);

    function automatic logic [W_DATA-1:0] default_color(input int i);
        logic [23:0] c;
        case (i)
            0:       c = 24'h010101;
            1:       c = 24'h010F01;
            2:       c = 24'h0F1F01;
            3:       c = 24'h0F0F01;
            4:       c = 24'h0F0101;
            5:       c = 24'h01010F;
            6:       c = 24'h01012F;
            7:       c = 24'h01803F;
            default: c = 24'h000000;
        endcase
        return W_DATA'(c);
    endfunction

    logic                start_q,   start_d;
    logic [W_DATA-1:0]   data_q,    data_d;
    logic                done_q,    done_d;
    logic [W_IDX-1:0]    phase_q,   phase_d;
    logic [W_CNT-1:0]    cnt_q,     cnt_d;
    logic [W_DATA-1:0]   palette_q [N_COLORS];
    logic [W_DATA-1:0]   palette_d [N_COLORS];

    logic                req;
    logic                do_step;
    logic [W_IDX-1:0]    row_i;
    logic [W_IDX-1:0]    col_i;
    logic [W_IDX-1:0]    pat;
    logic [W_IDX-1:0]    color_idx;

    // Pattern and palette lookup for the request edge.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path can infer a latch.
        row_i     = W_IDX'(addr[W_ADDR-1:COLS_LOG2]);
        col_i     = W_IDX'(addr[COLS_LOG2-1:0]);
        pat       = '0;
        case (mode)
            2'd0: pat = row_i ^ col_i;
            2'd1: pat = row_i;
            2'd2: pat = col_i;
            2'd3: pat = '0;
        endcase
        color_idx = pat + phase_q;

        start_d = start;
        req     = start && !start_q;
        done_d  = req;
        data_d  = data_q;
        // Reads the pre-write entry, so a same-edge palette write is seen one edge later.
        if (req) begin
            data_d = palette_q[color_idx];
        end

        palette_d = palette_q;
        if (pal_we) begin
            palette_d[pal_idx] = pal_wdata;
        end
    end

    // Period counter and phase rotation.
    always_comb begin
        cnt_d   = cnt_q;
        do_step = 1'b0;
        if (!pause) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                do_step = 1'b1;
            end else begin
                cnt_d = cnt_q + W_CNT'(1);
            end
        end else begin
            do_step = step;
        end

        phase_d = phase_q;
        if (do_step) begin
            phase_d = dir ? (phase_q - W_IDX'(1)) : (phase_q + W_IDX'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
            // NOTE: the palette is a reset register file, not a RAM, so reset restores the default colours.
            for (int i = 0; i < N_COLORS; i++) begin
                palette_q[i] <= default_color(i);
            end
        end else begin
            // NOTE: non-blocking updates make every flop sample the pre-edge values of the others.
            start_q   <= start_d;
            data_q    <= data_d;
            done_q    <= done_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            palette_q <= palette_d;
        end
    end

    assign data  = data_q;
    assign done  = done_q;
    assign phase = phase_q;

endmodule

// File: doc/ws2812_pattern_gen.md
Name: ws2812_pattern_gen

Overview:
Parametrised successor to the fixed 8×8 XOR colour generator for the WS2812 chain driver. It answers per-pixel colour requests (start/addr → data/done) from the serialiser. The colour comes from a writable palette, and the pattern is selectable (XOR checker, rows, columns, solid). A rotation phase advances every PERIOD clocks, with direction, pause and single-step control.

Parameters:
- W_ADDR, 6: pixel address width; the matrix holds 2^W_ADDR pixels.
- COLS_LOG2, 3: log2 of the matrix width. Column = addr[COLS_LOG2-1:0]; row = addr[W_ADDR-1:COLS_LOG2].
- W_DATA, 24: colour word width (GRB order, as the serialiser consumes).
- N_COLORS, 8: palette depth. Must be a power of two, 2..16. W_IDX = $clog2(N_COLORS).
- PERIOD, 30000000: clocks per rotation step, ≥2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: request strobe. A rising edge (sampled on clk) requests one pixel.
- addr, input, W_ADDR: pixel address, sampled on the rising-edge cycle of start.
- data, output, W_DATA: colour of the last requested pixel.
- done, output, 1: one-cycle pulse, data valid.
- mode, input, 2: pattern select: 0 XOR, 1 rows, 2 columns, 3 solid.
- dir, input, 1: rotation direction. 0 = phase+1, 1 = phase−1.
- pause, input, 1: freeze the period counter and the phase.
- step, input, 1: single-cycle pulse. Advances the phase by one step in dir while pause=1.
- pal_we, input, 1: palette write enable.
- pal_idx, input, W_IDX: palette write index.
- pal_wdata, input, W_DATA: palette write data.
- phase, output, W_IDX: current rotation phase (debug / 7-seg).

Behaviour:
- Reset (rst_n=0, async):
  - data=0, done=0, phase=0, period counter=0, start_q=0.
  - Palette entries 0..7 = 010101, 010F01, 0F1F01, 0F0F01, 0F0101, 01010F, 01012F, 01803F; entries ≥8 = 0.
  - For N_COLORS<8 only the lower entries apply.
- start_q is a registered copy of start. A request is start=1 && start_q=0 at a clk edge. Because start_q resets to 0, start held high across reset release triggers one request on the first edge.
- Pattern value p (computed from addr at the request edge):
  - mode 0: row^col.
  - mode 1: row.
  - mode 2: col.
  - mode 3: 0.
  - row and col are zero-extended to max(width) and p is truncated to W_IDX bits.
- Colour index = (p + phase) mod N_COLORS. Latency 1: at the request edge, data ← palette[index] and done ← 1.
- done stays high for exactly one cycle; it is 0 on every non-request edge. data holds until the next request.
- start held high produces one request only. The next request needs start to return low for ≥1 cycle.
- Period counter:
  - Counts 0..PERIOD-1 while pause=0. At PERIOD-1 it wraps to 0 and the phase steps (±1 mod N_COLORS per dir).
  - While pause=1 the counter and phase hold.
  - A step pulse with pause=1 steps the phase once. step is ignored while pause=0.
- Phase wrap: N_COLORS-1 +1 → 0; 0 −1 → N_COLORS-1.
- Simultaneous events:
  - A request on the same edge as a phase step uses the pre-step phase.
  - A palette write on the same edge as a request to the same index returns the old entry; the new value is visible from the next edge.
  - A mode or dir change takes effect at the next request or step edge.
- Reset mid-operation clears the palette to defaults and aborts any pending done.
- All state is on one clock. There are no derived clocks and no combinational path from the inputs to data/done.

Test Plan:
- Reset, then a pulse on start with addr=6'd9 (row1,col1), mode0, phase0 → 1 cycle later data=24'h010101 (index0), done high exactly 1 cycle.
- PERIOD=4, pause=0, dir=0; request addr=6'd1 every 4 cycles.
  - Required sequence: 010F01, 0F1F01, 0F0F01…
  - Phase wraps 7→0 after 8 steps and data returns to 010F01.
- dir=1 from phase0: after one period phase=7. Request addr=0 in mode3 → data=01803F. pause=1 then three step pulses → phase=4 and data=0F0101; the counter is frozen between steps.
- mode1/mode2 sweep over all 64 addrs at phase0: data index = row (mode1) and col (mode2). Compare against the model for every address.
- pal_we idx3=ABCDEF on the same edge as a request for index3 → data=0F0F01. The next request → ABCDEF.
- start held high 10 cycles → exactly one done pulse.
- Assert rst_n low mid-run → data=0, done=0, phase=0 immediately, and the palette is back to defaults.
